// File: rtl/ahb_matrix_pkg.sv
// Shared AHB encodings and burst helpers for the bus-matrix output stage.
package ahb_matrix_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;
   localparam logic [2:0] HBURST_WRAP4  = 3'b010;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;
   localparam logic [2:0] HBURST_WRAP8  = 3'b100;
   localparam logic [2:0] HBURST_INCR8  = 3'b101;
   localparam logic [2:0] HBURST_WRAP16 = 3'b110;
   localparam logic [2:0] HBURST_INCR16 = 3'b111;

   // Remaining beats after the first; zero for SINGLE and undefined-length INCR.
   function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
      logic [4:0] beats;
      case (hburst[2:1])
         2'b01:   beats = 5'd3;
         2'b10:   beats = 5'd7;
         2'b11:   beats = 5'd15;
         default: beats = 5'd0;
      endcase
      return beats;
   endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin pick: first requester after the last grant.
module ahb_rr_picker #(
   parameter int NUM_PORTS = 3,
   parameter int PORT_W    = 2
) (
   input  logic [NUM_PORTS-1:0] req_vec,
   input  logic [PORT_W-1:0]    last,
   output logic [PORT_W-1:0]    winner,
   output logic                 any_req
);

   always_comb begin
      winner  = '0;
      any_req = 1'b0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         for (int j = 0; j < NUM_PORTS; j++) begin
            if (!any_req && req_vec[j] &&
                j == (int'(last) + 1 + k) % NUM_PORTS) begin
               any_req = 1'b1;
               winner  = PORT_W'(j);
            end
         end
      end
   end

endmodule

// File: rtl/ahb_output_arbiter.sv
// Output-stage arbiter: address-phase grant with burst/lock hold,
// plus data-phase ownership tracking.
module ahb_output_arbiter
   import ahb_matrix_pkg::*;
#(
   parameter int NUM_PORTS = 3,
   parameter int PORT_W    = 2
) (
   input  logic                 HCLK,
   input  logic                 HRESET,
   input  logic [NUM_PORTS-1:0] req_vec,
   input  logic                 HREADYM,
   input  logic [1:0]           HTRANSM,
   input  logic [2:0]           HBURSTM,
   input  logic                 HMASTLOCKM,
   output logic [PORT_W-1:0]    addr_sel,
   output logic                 no_port,
   output logic [PORT_W-1:0]    data_sel,
   output logic                 data_active
);

   logic [PORT_W-1:0] addr_sel_q, addr_sel_d;
   logic              no_port_q, no_port_d;
   logic [PORT_W-1:0] data_sel_q;
   logic              data_active_q;
   logic [4:0]        cnt_q, cnt_d;
   logic [PORT_W-1:0] last_q, last_d;

   logic [PORT_W-1:0] winner;
   logic              any_req;
   logic              own_req;
   logic              hold;

   ahb_rr_picker #(
      .NUM_PORTS (NUM_PORTS),
      .PORT_W    (PORT_W)
   ) u_picker (
      .req_vec (req_vec),
      .last    (last_q),
      .winner  (winner),
      .any_req (any_req)
   );

   always_comb begin
      own_req = 1'b0;
      for (int j = 0; j < NUM_PORTS; j++) begin
         if (PORT_W'(j) == addr_sel_q && req_vec[j]) begin
            own_req = 1'b1;
         end
      end
   end

   always_comb begin
      cnt_d      = cnt_q;
      addr_sel_d = addr_sel_q;
      no_port_d  = no_port_q;
      last_d     = last_q;

      case (HTRANSM)
         HTRANS_NONSEQ: cnt_d = burst_beats(HBURSTM);
         HTRANS_SEQ:    if (cnt_q != 5'd0) cnt_d = cnt_q - 5'd1;
         HTRANS_IDLE:   cnt_d = 5'd0;
         default:       cnt_d = cnt_q;
      endcase

      hold = !no_port_q &&
             (HMASTLOCKM || cnt_d != 5'd0 ||
              (HBURSTM == HBURST_INCR && HTRANSM != HTRANS_IDLE) ||
              HTRANSM == HTRANS_BUSY);

      // Owner withdrew (e.g. ERROR): abandon the burst unless still locked.
      if (!own_req && !HMASTLOCKM) begin
         cnt_d = 5'd0;
         hold  = 1'b0;
      end

      if (!hold) begin
         if (any_req) begin
            addr_sel_d = winner;
            no_port_d  = 1'b0;
            last_d     = winner;
         end else begin
            no_port_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         addr_sel_q    <= '0;
         no_port_q     <= 1'b1;
         data_sel_q    <= '0;
         data_active_q <= 1'b0;
         cnt_q         <= 5'd0;
         last_q        <= PORT_W'(NUM_PORTS - 1);
      end else if (HREADYM) begin
         addr_sel_q    <= addr_sel_d;
         no_port_q     <= no_port_d;
         data_sel_q    <= addr_sel_q;
         data_active_q <= ~no_port_q & HTRANSM[1];
         cnt_q         <= cnt_d;
         last_q        <= last_d;
      end
   end

   assign addr_sel    = addr_sel_q;
   assign no_port     = no_port_q;
   assign data_sel    = data_sel_q;
   assign data_active = data_active_q;

endmodule

// File: tb/tb_ahb_output_arbiter.sv
// Scenario bench for ahb_output_arbiter: expected outputs are queued
// with each driven cycle and compared after the edge.
module tb_ahb_output_arbiter;
   import ahb_matrix_pkg::*;

   logic       HCLK = 1'b0;
   logic       HRESET;
   logic [2:0] req_vec;
   logic       HREADYM;
   logic [1:0] HTRANSM;
   logic [2:0] HBURSTM;
   logic       HMASTLOCKM;
   logic [1:0] addr_sel;
   logic       no_port;
   logic [1:0] data_sel;
   logic       data_active;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct packed {
      logic [2:0] r;
      logic       rdy;
      logic [1:0] t;
      logic [2:0] b;
      logic       l;
      logic [5:0] e;
   } step_t;

   logic [5:0] exp_q[$];
   logic [5:0] got, want;

   ahb_output_arbiter #(.NUM_PORTS(3), .PORT_W(2)) dut (
      .HCLK        (HCLK),
      .HRESET      (HRESET),
      .req_vec     (req_vec),
      .HREADYM     (HREADYM),
      .HTRANSM     (HTRANSM),
      .HBURSTM     (HBURSTM),
      .HMASTLOCKM  (HMASTLOCKM),
      .addr_sel    (addr_sel),
      .no_port     (no_port),
      .data_sel    (data_sel),
      .data_active (data_active)
   );

   always #5 HCLK = ~HCLK;

   // {addr_sel, no_port, data_sel, data_active}
   function automatic logic [5:0] E(input int a, input bit np,
                                    input int d, input bit da);
      return {2'(a), np, 2'(d), da};
   endfunction

   function automatic step_t S(input logic [2:0] r, input logic rdy,
                               input logic [1:0] t, input logic [2:0] b,
                               input logic l, input logic [5:0] e);
      return '{r: r, rdy: rdy, t: t, b: b, l: l, e: e};
   endfunction

   task automatic apply(input step_t s);
      req_vec    = s.r;
      HREADYM    = s.rdy;
      HTRANSM    = s.t;
      HBURSTM    = s.b;
      HMASTLOCKM = s.l;
      exp_q.push_back(s.e);
      @(posedge HCLK);
      #1;
   endtask

   task automatic test_reset();
      step_t s[$];
      HRESET = 1'b1;
      req_vec = '0; HREADYM = 1'b1; HTRANSM = HTRANS_IDLE;
      HBURSTM = HBURST_SINGLE; HMASTLOCKM = 1'b0;
      repeat (2) @(posedge HCLK);
      #1;
      got = {addr_sel, no_port, data_sel, data_active};
      n_chk++;
      if (got !== E(0, 1, 0, 0)) begin
         n_fail++;
         $display("FAIL reset_values: got %b required %b", got, E(0, 1, 0, 0));
      end
      HRESET = 1'b0;
      repeat (4) s.push_back(S(3'b000, 1, HTRANS_IDLE, HBURST_SINGLE, 0, E(0, 1, 0, 0)));
      foreach (s[i]) begin
         apply(s[i]);
         want = exp_q.pop_front();
         got  = {addr_sel, no_port, data_sel, data_active};
         n_chk++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL idle_no_req step %0d: got %b required %b", i, got, want);
         end
      end
   endtask

   task automatic test_round_robin();
      step_t s[$];
      s.push_back(S(3'b111, 1, HTRANS_NONSEQ, HBURST_SINGLE, 0, E(0, 0, 0, 0)));
      s.push_back(S(3'b111, 1, HTRANS_NONSEQ, HBURST_SINGLE, 0, E(1, 0, 0, 1)));
      s.push_back(S(3'b111, 1, HTRANS_NONSEQ, HBURST_SINGLE, 0, E(2, 0, 1, 1)));
      s.push_back(S(3'b111, 1, HTRANS_NONSEQ, HBURST_SINGLE, 0, E(0, 0, 2, 1)));
      s.push_back(S(3'b111, 1, HTRANS_NONSEQ, HBURST_SINGLE, 0, E(1, 0, 0, 1)));
      s.push_back(S(3'b111, 1, HTRANS_NONSEQ, HBURST_SINGLE, 0, E(2, 0, 1, 1)));
      foreach (s[i]) begin
         apply(s[i]);
         want = exp_q.pop_front();
         got  = {addr_sel, no_port, data_sel, data_active};
         n_chk++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL round_robin step %0d: got %b required %b", i, got, want);
         end
      end
   endtask

   task automatic test_incr4_wait();
      step_t s[$];
      s.push_back(S(3'b010, 1, HTRANS_IDLE,   HBURST_SINGLE, 0, E(1, 0, 2, 0)));
      s.push_back(S(3'b111, 1, HTRANS_NONSEQ, HBURST_INCR4,  0, E(1, 0, 1, 1)));
      s.push_back(S(3'b111, 0, HTRANS_SEQ,    HBURST_INCR4,  0, E(1, 0, 1, 1)));
      s.push_back(S(3'b111, 1, HTRANS_SEQ,    HBURST_INCR4,  0, E(1, 0, 1, 1)));
      s.push_back(S(3'b111, 1, HTRANS_SEQ,    HBURST_INCR4,  0, E(1, 0, 1, 1)));
      s.push_back(S(3'b111, 1, HTRANS_SEQ,    HBURST_INCR4,  0, E(2, 0, 1, 1)));
      foreach (s[i]) begin
         apply(s[i]);
         want = exp_q.pop_front();
         got  = {addr_sel, no_port, data_sel, data_active};
         n_chk++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL incr4_wait step %0d: got %b required %b", i, got, want);
         end
      end
   endtask

   task automatic test_lock();
      step_t s[$];
      s.push_back(S(3'b001, 1, HTRANS_IDLE,   HBURST_SINGLE, 0, E(0, 0, 2, 0)));
      s.push_back(S(3'b101, 1, HTRANS_IDLE,   HBURST_SINGLE, 1, E(0, 0, 0, 0)));
      s.push_back(S(3'b101, 1, HTRANS_NONSEQ, HBURST_SINGLE, 1, E(0, 0, 0, 1)));
      s.push_back(S(3'b100, 1, HTRANS_NONSEQ, HBURST_SINGLE, 1, E(0, 0, 0, 1)));
      s.push_back(S(3'b101, 1, HTRANS_IDLE,   HBURST_SINGLE, 0, E(2, 0, 0, 0)));
      foreach (s[i]) begin
         apply(s[i]);
         want = exp_q.pop_front();
         got  = {addr_sel, no_port, data_sel, data_active};
         n_chk++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL lock_hold step %0d: got %b required %b", i, got, want);
         end
      end
   endtask

   task automatic test_early_term();
      step_t s[$];
      s.push_back(S(3'b111, 1, HTRANS_NONSEQ, HBURST_INCR8, 0, E(2, 0, 2, 1)));
      s.push_back(S(3'b111, 1, HTRANS_SEQ,    HBURST_INCR8, 0, E(2, 0, 2, 1)));
      s.push_back(S(3'b111, 1, HTRANS_SEQ,    HBURST_INCR8, 0, E(2, 0, 2, 1)));
      s.push_back(S(3'b011, 1, HTRANS_SEQ,    HBURST_INCR8, 0, E(0, 0, 2, 1)));
      s.push_back(S(3'b011, 1, HTRANS_SEQ,    HBURST_INCR4, 0, E(1, 0, 0, 1)));
      foreach (s[i]) begin
         apply(s[i]);
         want = exp_q.pop_front();
         got  = {addr_sel, no_port, data_sel, data_active};
         n_chk++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL early_term step %0d: got %b required %b", i, got, want);
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      step_t s[$];
      step_t p[$];
      s.push_back(S(3'b111, 1, HTRANS_NONSEQ, HBURST_INCR16, 0, E(1, 0, 1, 1)));
      repeat (4) s.push_back(S(3'b111, 1, HTRANS_SEQ, HBURST_INCR16, 0, E(1, 0, 1, 1)));
      foreach (s[i]) begin
         apply(s[i]);
         want = exp_q.pop_front();
         got  = {addr_sel, no_port, data_sel, data_active};
         n_chk++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL incr16_pre_reset step %0d: got %b required %b", i, got, want);
         end
      end
      #2 HRESET = 1'b1;
      #1;
      got = {addr_sel, no_port, data_sel, data_active};
      n_chk++;
      if (got !== E(0, 1, 0, 0)) begin
         n_fail++;
         $display("FAIL async_reset: got %b required %b", got, E(0, 1, 0, 0));
      end
      @(negedge HCLK);
      HRESET = 1'b0;
      p.push_back(S(3'b111, 1, HTRANS_SEQ, HBURST_INCR4, 0, E(0, 0, 0, 0)));
      p.push_back(S(3'b111, 1, HTRANS_SEQ, HBURST_INCR4, 0, E(1, 0, 0, 1)));
      foreach (p[i]) begin
         apply(p[i]);
         want = exp_q.pop_front();
         got  = {addr_sel, no_port, data_sel, data_active};
         n_chk++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL post_reset step %0d: got %b required %b", i, got, want);
         end
      end
   endtask

   task automatic test_back_to_back();
      step_t s[$];
      s.push_back(S(3'b001, 1, HTRANS_NONSEQ, HBURST_SINGLE, 0, E(0, 0, 1, 1)));
      repeat (3) s.push_back(S(3'b001, 1, HTRANS_NONSEQ, HBURST_SINGLE, 0, E(0, 0, 0, 1)));
      s.push_back(S(3'b000, 1, HTRANS_IDLE, HBURST_SINGLE, 0, E(0, 1, 0, 0)));
      s.push_back(S(3'b000, 1, HTRANS_IDLE, HBURST_SINGLE, 0, E(0, 1, 0, 0)));
      foreach (s[i]) begin
         apply(s[i]);
         want = exp_q.pop_front();
         got  = {addr_sel, no_port, data_sel, data_active};
         n_chk++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL back_to_back step %0d: got %b required %b", i, got, want);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_round_robin();
      test_incr4_wait();
      test_lock();
      test_early_term();
      test_reset_mid_burst();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
